// File: rtl/usb_sie_rx_ms.sv
`default_nettype none
// ============================================================================
// Module   : usb_sie_rx_ms
// Purpose  : USB receive-side SIE. Synchronises and glitch-filters the D+/D-
//            pads, recovers bits by oversampling with phase resync on every
//            accepted transition, then NRZI-decodes, unstuffs, detects
//            SYNC/EOP, assembles bytes and flags bus reset.
// Ports    : clk, rst (sync, active-high)
//            dn_rx, dp_rx      - asynchronous pad inputs
//            ls_mode           - low-speed polarity (sampled while idle)
//            tx_active         - transmitter busy, line is ignored
//            rx_data/rx_valid  - received byte strobe
//            rx_active         - packet in progress
//            rx_error/rx_err_code - error pulse and sticky code
//            rx_byte_cnt       - bytes delivered in current/last packet
//            line_state        - filtered line state (00 SE0, 01 J, 10 K)
//            bus_reset         - bus reset detected
// Revision : 1.0 - initial release
// ============================================================================
module usb_sie_rx_ms #(
  parameter int OVERSAMPLE   = 4,
  parameter int MAX_BYTES    = 1027,
  parameter int RESET_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dn_rx,
  input  logic                             dp_rx,
  input  logic                             ls_mode,
  input  logic                             tx_active,
  output logic [7:0]                       rx_data,
  output logic                             rx_valid,
  output logic                             rx_active,
  output logic                             rx_error,
  output logic [1:0]                       rx_err_code,
  output logic [$clog2(MAX_BYTES+1)-1:0]   rx_byte_cnt,
  output logic [1:0]                       line_state,
  output logic                             bus_reset
);

  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(MAX_BYTES + 1);
  localparam int RST_W = $clog2(RESET_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_STB  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(MAX_BYTES);
  localparam logic [RST_W-1:0] RST_MAX = RST_W'(RESET_CYCLES);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;

  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OVFL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_ERR_WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [1:0]      sync1_q, sync2_q, hold_q, filt_q;
  logic [PH_W-1:0] phase_q;
  logic [1:0]      last_jk_q;
  logic [3:0]      hist_q;      // [3:2] older sample, [1:0] newer sample
  logic [2:0]      ones_q;
  logic [6:0]      sync_sr_q;   // previous 7 decoded bits, oldest at MSB
  logic [6:0]      shreg_q;
  logic [2:0]      bitcnt_q;
  logic [BC_W-1:0] byte_cnt_q;
  logic            pol_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q, rx_active_q, rx_error_q, bus_reset_q;
  logic [1:0]      rx_err_code_q, line_state_q;
  logic [RST_W-1:0] se0_cnt_q;

  // Pair {dn,dp}: equal bits are SE0 (SE1 folded in); low speed swaps J/K.
  function automatic logic [1:0] f_decode(input logic [1:0] pair, input logic pol);
    if (pair[1] == pair[0]) return LS_SE0;
    return pol ? {pair[0], pair[1]} : pair;
  endfunction

  logic       w_pol, w_accept, w_strobe, w_bit_vld, w_bit, w_eop;
  logic       w_stuff_slot, w_stuff_err, w_data_vld, w_overflow, w_sync_hit;
  logic [1:0] w_line;

  always_comb begin
    // Polarity is live while idle and frozen for the rest of a packet.
    w_pol        = (state_q == S_IDLE) ? ls_mode : pol_q;
    w_line       = f_decode(filt_q, w_pol);
    w_accept     = (sync2_q == hold_q) && (sync2_q != filt_q);
    w_strobe     = (phase_q == PH_STB);
    w_bit_vld    = w_strobe && (w_line != LS_SE0);
    w_bit        = (w_line == last_jk_q);
    w_eop        = w_strobe && (hist_q[3:2] == LS_SE0) && (hist_q[1:0] == LS_SE0)
                   && (w_line == LS_J);
    // The bit following six 1s is a stuff slot only inside a packet.
    w_stuff_slot = w_bit_vld && (ones_q == 3'd6) && (state_q != S_IDLE);
    w_stuff_err  = w_stuff_slot && w_bit && (state_q == S_ACTIVE);
    w_data_vld   = w_bit_vld && !w_stuff_slot;
    w_overflow   = (state_q == S_ACTIVE) && w_data_vld && !w_eop
                   && (bitcnt_q == 3'd7) && (byte_cnt_q == BC_MAX);
    w_sync_hit   = (state_q == S_IDLE) && w_data_vld && !tx_active
                   && ({sync_sr_q, w_bit} == 8'h01);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync1_q       <= LS_J;
      sync2_q       <= LS_J;
      hold_q        <= LS_J;
      filt_q        <= LS_J;
      phase_q       <= '0;
      last_jk_q     <= LS_J;
      hist_q        <= {LS_J, LS_J};
      ones_q        <= '0;
      sync_sr_q     <= 7'h7F;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      byte_cnt_q    <= '0;
      pol_q         <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_active_q   <= 1'b0;
      rx_error_q    <= 1'b0;
      rx_err_code_q <= '0;
      line_state_q  <= LS_J;
      se0_cnt_q     <= '0;
      bus_reset_q   <= 1'b0;
    end else begin
      sync1_q      <= {dn_rx, dp_rx};
      sync2_q      <= sync1_q;
      hold_q       <= sync2_q;
      if (w_accept) filt_q <= sync2_q;
      phase_q      <= (w_accept || phase_q == PH_MAX) ? '0 : phase_q + PH_W'(1);
      line_state_q <= w_line;

      // Bus reset: saturating SE0 run counter, independent of the FSM.
      if (w_line == LS_SE0) begin
        if (se0_cnt_q != RST_MAX) se0_cnt_q <= se0_cnt_q + RST_W'(1);
        bus_reset_q <= (se0_cnt_q == RST_MAX);
      end else begin
        se0_cnt_q   <= '0;
        bus_reset_q <= 1'b0;
      end

      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;

      if (w_strobe) hist_q <= {hist_q[1:0], w_line};

      if (w_bit_vld) begin
        last_jk_q <= w_line;
        if (w_stuff_slot || !w_bit) ones_q <= '0;
        else if (ones_q != 3'd6)    ones_q <= ones_q + 3'd1;
      end
      if (w_data_vld) sync_sr_q <= {sync_sr_q[5:0], w_bit};

      case (state_q)
        S_IDLE: begin
          if (w_sync_hit) begin
            state_q     <= S_ACTIVE;
            rx_active_q <= 1'b1;
            byte_cnt_q  <= '0;
            bitcnt_q    <= '0;
            pol_q       <= ls_mode;
          end
        end
        S_ACTIVE: begin
          if (w_overflow) begin
            state_q       <= S_ERR_WAIT;
            rx_error_q    <= 1'b1;
            rx_err_code_q <= ERR_OVFL;
          end else if (w_stuff_err) begin
            state_q       <= S_ERR_WAIT;
            rx_error_q    <= 1'b1;
            rx_err_code_q <= ERR_STUFF;
          end else if (w_eop || tx_active) begin
            state_q     <= S_IDLE;
            rx_active_q <= 1'b0;
            sync_sr_q   <= 7'h7F;  // packet bits must not seed a false SYNC
            if (w_eop && bitcnt_q != 3'd0) begin
              rx_error_q    <= 1'b1;
              rx_err_code_q <= ERR_ALIGN;
            end
          end else if (w_data_vld) begin
            shreg_q  <= {w_bit, shreg_q[6:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_q  <= {w_bit, shreg_q};
              rx_valid_q <= 1'b1;
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
            end
          end
        end
        S_ERR_WAIT: begin
          if (w_eop || tx_active) begin
            state_q     <= S_IDLE;
            rx_active_q <= 1'b0;
            sync_sr_q   <= 7'h7F;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_active   = rx_active_q;
  assign rx_error    = rx_error_q;
  assign rx_err_code = rx_err_code_q;
  assign rx_byte_cnt = byte_cnt_q;
  assign line_state  = line_state_q;
  assign bus_reset   = bus_reset_q;

endmodule
`default_nettype wire
